expr_response_misr: RTL and testbench
=====================================

Name: expr_response_misr

Overview:
- Downstream response compactor for the generated expression blocks.
- Accepts a stream of 90-bit expression result words (the concatenated y0..y17 bus) over a valid/ready handshake.
- Compresses the stream into a 32-bit MISR signature and compares it against a golden value at the end of a run.
- The regression harness places one instance after each expression DUT and reads only pass/done, not every output.

Parameters:
- DATA_W, 90, width of the incoming result word.
- COUNT_W, 16, width of the sample counters and of num_samples.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, MISR value loaded at run start.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- num_samples  input  COUNT_W  number of words in the run, sampled when start is accepted.
- expected_sig  input  32  golden signature, sampled in CHECK.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  result word.
- in_ready  output  1  block accepts a word this cycle.
- busy  output  1  high in RUN and CHECK.
- done  output  1  run complete; held until the next start or reset.
- pass  output  1  signature matched; meaningful only while done=1.
- signature  output  32  current MISR value.
- sample_count  output  COUNT_W  words folded into the MISR so far.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-low, sampled on the clk rising edge.
  - Reset overrides every other input, including start.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, pass=0, signature=SEED, sample_count=0, internal accepted counter=0, stage valid=0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE or DONE with start=1:
  - Load target=num_samples, signature=SEED, accepted=0, sample_count=0.
  - Clear done and pass.
  - Next state is RUN if target!=0, otherwise CHECK.
  - start in RUN or CHECK is ignored.
- RUN:
  - in_ready = (accepted < target); it is combinational from registers only, with no path from in_valid.
  - Handshake is in_valid & in_ready: capture in_data into a one-deep stage register, set stage valid, accepted++.
  - Words offered while in_ready=0 are not consumed.
- MISR update (cycle after capture, stage valid=1):
  - fold = in_q[31:0] ^ in_q[63:32] ^ {6'b0, in_q[89:64]}.
  - signature <= {signature[30:0],1'b0} ^ (signature[31] ? POLY : 0) ^ fold.
  - sample_count++.
  - Capture and update pipeline back-to-back at one word per cycle.
- RUN to CHECK:
  - The transition happens on the same edge as the update that makes sample_count equal target.
  - in_ready is already 0 by then, because accepted==target.
- CHECK:
  - Lasts one cycle.
  - pass <= (signature == expected_sig), done <= 1, then go to DONE.
- DONE: done, pass and signature are held; in_ready=0; busy=0.
- Latency with start accepted at edge 0 and in_valid held high:
  - Words are accepted at edges 1..N; done rises at edge N+2.
  - For N=0, done rises at edge 1.
- Wrap and limits:
  - num_samples=2^COUNT_W-1 is legal.
  - Counters never wrap, because acceptance stops at target.
- Mid-run stall: in_valid=0 simply pauses the run; there is no timeout.
- Reset mid-run: everything returns to reset values on that edge. A word in the stage register is discarded.
- Simultaneous events:
  - start together with in_valid in IDLE or DONE: the word is not accepted (in_ready=0 that cycle).
  - rst_n=0 together with start: reset wins.

Test Plan:
- Zero-length run: reset, then start with num_samples=0 and expected_sig=32'hFFFFFFFF -> done=1 one cycle later, pass=1, signature=32'hFFFFFFFF, sample_count=0, in_ready never high.
- Single zero word: num_samples=1, in_data=0, expected_sig=32'hFB3EE249 -> signature=32'hFB3EE249, pass=1, done at edge 3.
- Mismatch: same run as the single zero word with expected_sig=32'hFB3EE248 -> done=1, pass=0.
- Back-to-back with stalls:
  - Stimulus: num_samples=8; words from the expression DUT driven by an LFSR; in_valid toggled pseudo-randomly.
  - Required response: signature equals the reference-model MISR; exactly 8 handshakes; in_ready=0 after the 8th; extra offered words are not consumed.
- Reset mid-run: assert rst_n=0 after 3 of 8 words -> next cycle state IDLE, signature=SEED, done=0, sample_count=0.
  - A fresh run after that reset must produce the same signature as an uninterrupted run.
- Restart from DONE and ignored start:
  - start in DONE with num_samples=2 -> done cleared on that edge, new signature computed from SEED.
  - start pulsed during RUN -> no effect on target or counters.

Source files
------------

// File: rtl/expr_response_misr.sv
// Response compactor: folds a stream of expression result words into a
// 32-bit MISR signature and compares it to a golden value at end of run.
//
// state  | meaning
// IDLE   | waiting for start after reset
// RUN    | accepting words until target reached and last word folded
// CHECK  | one cycle: compare signature to expected_sig
// DONE   | result held until next start
module expr_response_misr #(
    parameter int          DATA_W  = 90,
    parameter int          COUNT_W = 16,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_samples,
    input  logic [31:0]        expected_sig,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [31:0]        signature,
    output logic [COUNT_W-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [COUNT_W-1:0] target_q;
    logic [COUNT_W-1:0] accepted_q;
    logic [COUNT_W-1:0] sample_count_q;
    logic               stage_valid_q;
    logic [DATA_W-1:0]  in_q;
    logic [31:0]        signature_q;
    logic               done_q;
    logic               pass_q;

    logic               start_ok;
    logic               fire;
    logic               last_fold;
    logic [95:0]        word_ext;
    logic [31:0]        fold;
    logic [31:0]        sig_next;

    // Zero-extend the staged word to three 32-bit lanes; the top lane
    // carries the upper DATA_W-64 bits.
    assign word_ext  = 96'(in_q);
    assign fold      = word_ext[31:0] ^ word_ext[63:32] ^ word_ext[95:64];
    assign sig_next  = {signature_q[30:0], 1'b0}
                     ^ (signature_q[31] ? POLY : 32'h0)
                     ^ fold;

    // in_ready depends on registers only, never on in_valid.
    assign in_ready  = (state_q == S_RUN) && (accepted_q < target_q);
    assign fire      = in_valid && in_ready;
    assign last_fold = stage_valid_q && ((sample_count_q + COUNT_W'(1)) == target_q);

    assign busy         = (state_q == S_RUN) || (state_q == S_CHECK);
    assign done         = done_q;
    assign pass         = pass_q;
    assign signature    = signature_q;
    assign sample_count = sample_count_q;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = (num_samples != '0) ? S_RUN : S_CHECK;
                end
            end
            S_RUN: begin
                if (last_fold) state_d = S_CHECK;
            end
            S_CHECK: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Capture stage, MISR, counters and result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q       <= '0;
            accepted_q     <= '0;
            sample_count_q <= '0;
            stage_valid_q  <= 1'b0;
            in_q           <= '0;
            signature_q    <= SEED;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            stage_valid_q <= fire;
            if (fire) begin
                in_q       <= in_data;
                accepted_q <= accepted_q + COUNT_W'(1);
            end
            if (stage_valid_q) begin
                signature_q    <= sig_next;
                sample_count_q <= sample_count_q + COUNT_W'(1);
            end
            if (state_q == S_CHECK) begin
                pass_q <= (signature_q == expected_sig);
                done_q <= 1'b1;
            end
            if (start_ok) begin
                target_q       <= num_samples;
                accepted_q     <= '0;
                sample_count_q <= '0;
                stage_valid_q  <= 1'b0;
                signature_q    <= SEED;
                done_q         <= 1'b0;
                pass_q         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_expr_response_misr.sv
// Self-checking bench for expr_response_misr: a transaction-level model
// (queue of accepted words, fold/done edges) checked every cycle, plus
// directed runs with hand-computed signatures.
module tb_expr_response_misr;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic [31:0] expected_sig = '0;
    logic        in_valid = 1'b0;
    logic [89:0] in_data = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] sample_count;

    expr_response_misr dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .expected_sig(expected_sig), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] w);
        logic [31:0] f;
        f = w[31:0] ^ w[63:32] ^ {6'b0, w[89:64]};
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    // Model: words accepted in the current run and the edge each one folds.
    logic [89:0] mq[$];
    int          mfold[$];
    int          edge_cnt = 0;
    int          target = 0;
    int          done_edge = -1;
    bit          active = 0;
    bit          armed = 0;
    logic [31:0] mexp = '0;

    function automatic logic [31:0] misr_of(input int cnt);
        logic [31:0] s;
        s = SEED;
        for (int i = 0; i < cnt; i++) s = misr_step(s, mq[i]);
        return s;
    endfunction

    always @(posedge clk) edge_cnt++;

    // Per-cycle compare against the model, then advance the model for the
    // upcoming edge using the inputs that edge will see.
    always @(negedge clk) begin
        bit done_now;
        int nf;
        done_now = active && (done_edge >= 0) && (edge_cnt >= done_edge);
        if (armed) begin
            nf = 0;
            foreach (mfold[i]) if (mfold[i] <= edge_cnt) nf++;
            chk("busy", 32'(busy), 32'(active && !done_now));
            chk("in_ready", 32'(in_ready), 32'(active && (mq.size() < target)));
            chk("done", 32'(done), 32'(done_now));
            chk("pass", 32'(pass), 32'(done_now && (misr_of(mq.size()) == mexp)));
            chk("signature", signature, misr_of(nf));
            chk("sample_count", 32'(sample_count), 32'(nf));
        end
        if (!rst_n) begin
            armed = 1;
            active = 0;
            mq.delete();
            mfold.delete();
            done_edge = -1;
            target = 0;
        end else if (start && (!active || done_now)) begin
            active = 1;
            mq.delete();
            mfold.delete();
            target = int'(num_samples);
            mexp = expected_sig;
            done_edge = (num_samples == 0) ? edge_cnt + 2 : -1;
        end else if (active && in_valid && (mq.size() < target)) begin
            mq.push_back(in_data);
            mfold.push_back(edge_cnt + 2);
            if (mq.size() == target) done_edge = edge_cnt + 3;
        end
    end

    logic [89:0] cur_words[16];
    logic [31:0] xs = 32'h1234ABCD;

    function automatic logic [31:0] xorshift(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic drive_word(input bit rnd_valid);
        int          idx;
        logic [95:0] r;
        idx = mq.size();
        in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (idx < 16) in_data = cur_words[idx];
        else begin
            r = {$urandom(), $urandom(), $urandom()};
            in_data = r[89:0];
        end
    endtask

    // One run. lat = edges from start acceptance to done; -1 if aborted.
    task automatic do_run(input int n, input logic [31:0] exp, input bit rnd_valid,
                          input int stray_at, input int abort_at, output int lat);
        int k;
        @(posedge clk); #1;
        start = 1'b1;
        num_samples = 16'(n);
        expected_sig = exp;
        drive_word(rnd_valid);
        @(posedge clk); #1;
        start = 1'b0;
        drive_word(rnd_valid);
        k = 0;
        lat = -1;
        while (k < 300) begin
            @(posedge clk); k++; #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (abort_at >= 0 && mq.size() == abort_at) begin
                rst_n = 1'b0;
                start = 1'b1;
                @(posedge clk); #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_sig", signature, SEED);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_count", 32'(sample_count), 32'd0);
                rst_n = 1'b1;
                start = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (k == stray_at) begin
                start = 1'b1;
                num_samples = 16'd5;
            end
            drive_word(rnd_valid);
        end
        in_valid = 1'b0;
        if (lat < 0) chk("done_timeout", 32'(k), 32'hFFFF_FFFF);
    endtask

    initial begin
        int          lat;
        logic [31:0] ref_sig;
        logic [95:0] r;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_zero_word", misr_step(SEED, 90'd0), 32'hFB3EE249);

        // Zero-length run, word offered alongside start must be ignored
        do_run(0, 32'hFFFFFFFF, 1'b0, -1, -1, lat);
        chk("zero_lat", 32'(lat), 32'd1);
        chk("zero_sig", signature, 32'hFFFFFFFF);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_count", 32'(sample_count), 32'd0);

        // Single zero word, matching and mismatching golden
        cur_words[0] = '0;
        do_run(1, 32'hFB3EE249, 1'b0, -1, -1, lat);
        chk("one_lat", 32'(lat), 32'd3);
        chk("one_sig", signature, 32'hFB3EE249);
        chk("one_pass", 32'(pass), 32'd1);
        do_run(1, 32'hFB3EE248, 1'b0, -1, -1, lat);
        chk("mis_done", 32'(done), 32'd1);
        chk("mis_pass", 32'(pass), 32'd0);

        // Restart from DONE; words pin every fold lane
        cur_words[0] = {26'd1, 32'd0, 32'd0};
        cur_words[1] = {26'd0, 32'h5, 32'h5};
        do_run(2, 32'hF2BCD927, 1'b0, -1, -1, lat);
        chk("two_lat", 32'(lat), 32'd4);
        chk("two_sig", signature, 32'hF2BCD927);
        chk("two_pass", 32'(pass), 32'd1);

        // Eight LFSR-driven words with random stalls
        for (int i = 0; i < 16; i++) begin
            xs = xorshift(xs); r[31:0] = xs;
            xs = xorshift(xs); r[63:32] = xs;
            xs = xorshift(xs); r[95:64] = xs;
            cur_words[i] = r[89:0];
        end
        ref_sig = SEED;
        for (int i = 0; i < 8; i++) ref_sig = misr_step(ref_sig, cur_words[i]);
        do_run(8, ref_sig, 1'b1, -1, -1, lat);
        chk("lfsr_sig", signature, ref_sig);
        chk("lfsr_pass", 32'(pass), 32'd1);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lfsr_count", 32'(sample_count), 32'd8);
        chk("lfsr_handshakes", 32'(mq.size()), 32'd8);

        // Start pulsed mid-run is ignored
        do_run(8, ref_sig, 1'b1, 2, -1, lat);
        chk("stray_sig", signature, ref_sig);
        chk("stray_count", 32'(sample_count), 32'd8);

        // Reset after three words (start asserted with it), then a clean rerun
        do_run(8, ref_sig, 1'b0, -1, 3, lat);
        @(posedge clk); #1;
        do_run(8, ref_sig, 1'b0, -1, -1, lat);
        chk("rerun_lat", 32'(lat), 32'd10);
        chk("rerun_sig", signature, ref_sig);
        chk("rerun_pass", 32'(pass), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
